// File: rtl/booth_pkg.sv
// Shared types and helpers for the booth MAC datapath.
// Holds the product width, accumulator FSM states and a sign-extension helper.
package booth_pkg;

    localparam int PROD_W = 16;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } acc_state_t;

    // Sign-extends the low w bits of v to 64 bits.
    function automatic logic [63:0] sext(input logic [63:0] v,
                                         input int unsigned w);
        logic [63:0] hi;
        logic        sgn;
        hi  = ~64'd0 << w;
        sgn = |(v & (64'd1 << (w - 1)));
        return sgn ? (v | hi) : (v & ~hi);
    endfunction

endpackage

// File: rtl/booth_product_accumulator_sat_add.sv
// W-bit signed adder with overflow detect; clamps to the signed range
// when BOOTH_ACC_SATURATE_EN is defined, wraps otherwise.
//   a_i, b_i : signed addends
//   sum_o    : sum (wrapped or clamped)
//   ovf_o    : signed overflow of a_i + b_i
module sat_add
    import booth_pkg::*;
#(
    parameter int W = 24
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

    logic [W-1:0] raw;

    assign raw   = a_i + b_i;
    // Overflow only when both addends agree in sign and the result does not.
    assign ovf_o = (a_i[W-1] == b_i[W-1]) && (raw[W-1] != a_i[W-1]);

`ifdef BOOTH_ACC_SATURATE_EN
    localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    assign sum_o = ovf_o ? (a_i[W-1] ? MINV : MAXV) : raw;
`else
    assign sum_o = raw;
`endif

endmodule

// File: rtl/booth_product_accumulator.sv
// Accumulates LEN signed products from booth_multiplier into one dot-product
// sum, with valid/ready on both sides. Result is held until consumed.
// Optional clamping on overflow: define BOOTH_ACC_SATURATE_EN.
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   in_valid/in_ready     : product handshake, in_product signed PROD_W
//   out_valid/out_ready   : result handshake, out_sum signed ACC_W
//   out_overflow          : sticky signed overflow for the held block
//   busy                  : part of a block has been accepted
module booth_product_accumulator #(
    parameter int PROD_W = booth_pkg::PROD_W,
    parameter int ACC_W  = 24,
    parameter int LEN    = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_overflow,
    output logic              busy
);
    import booth_pkg::*;

    localparam int              CNT_W = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    acc_state_t       state_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sticky_q;
    logic             valid_q;
    logic             ovf_q;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] add_a;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic             accept;

    assign in_ready = (state_q == ACCUM) || out_ready;
    assign accept   = in_valid && in_ready;
    assign prod_ext = ACC_W'(sext(64'(in_product), PROD_W));
    // In DONE an accepted product opens a fresh block, so add it to zero.
    assign add_a    = (state_q == DONE) ? '0 : acc_q;

    sat_add #(
        .W(ACC_W)
    ) u_add (
        .a_i   (add_a),
        .b_i   (prod_ext),
        .sum_o (add_sum),
        .ovf_o (add_ovf)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ACCUM;
            acc_q    <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (accept) begin
                        if (cnt_q == LAST) begin
                            sum_q    <= add_sum;
                            ovf_q    <= sticky_q | add_ovf;
                            valid_q  <= 1'b1;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                            sticky_q <= 1'b0;
                            state_q  <= DONE;
                        end else begin
                            acc_q    <= add_sum;
                            cnt_q    <= cnt_q + CNT_W'(1);
                            sticky_q <= sticky_q | add_ovf;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        if (!in_valid) begin
                            valid_q <= 1'b0;
                            state_q <= ACCUM;
                        end else if (LEN == 1) begin
                            sum_q <= add_sum;
                            ovf_q <= add_ovf;
                        end else begin
                            acc_q    <= add_sum;
                            cnt_q    <= CNT_W'(1);
                            sticky_q <= add_ovf;
                            valid_q  <= 1'b0;
                            state_q  <= ACCUM;
                        end
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign out_valid    = valid_q;
    assign out_sum      = sum_q;
    assign out_overflow = ovf_q;
    assign busy         = (cnt_q != '0);

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Self-checking bench for booth_product_accumulator.
// Three instances: LEN=4/ACC_W=24, LEN=4/ACC_W=16, LEN=1/ACC_W=24.
module tb_booth_product_accumulator;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // Instance A: LEN=4, ACC_W=24
    logic        a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
    logic [15:0] a_in_product = '0;
    logic [23:0] a_out_sum;
    logic        a_out_overflow, a_busy;

    // Instance B: LEN=4, ACC_W=16
    logic        b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
    logic [15:0] b_in_product = '0;
    logic [15:0] b_out_sum;
    logic        b_out_overflow, b_busy;

    // Instance C: LEN=1, ACC_W=24
    logic        c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0;
    logic [15:0] c_in_product = '0;
    logic [23:0] c_out_sum;
    logic        c_out_overflow, c_busy;

    booth_product_accumulator #(.PROD_W(16), .ACC_W(24), .LEN(4)) dut_a (
        .clock(clock), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_product(a_in_product),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sum(a_out_sum),
        .out_overflow(a_out_overflow), .busy(a_busy)
    );

    booth_product_accumulator #(.PROD_W(16), .ACC_W(16), .LEN(4)) dut_b (
        .clock(clock), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_product(b_in_product),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum),
        .out_overflow(b_out_overflow), .busy(b_busy)
    );

    booth_product_accumulator #(.PROD_W(16), .ACC_W(24), .LEN(1)) dut_c (
        .clock(clock), .reset(reset),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_product(c_in_product),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_sum(c_out_sum),
        .out_overflow(c_out_overflow), .busy(c_busy)
    );

`ifdef BOOTH_ACC_SATURATE_EN
    localparam logic [15:0] B_OVF_SUM = 16'h7FFF;
`else
    localparam logic [15:0] B_OVF_SUM = 16'h0000;
`endif

    int n_pass = 0;
    int n_total = 0;

    logic [15:0] seq [4] = '{16'h0222, 16'hFBA2, 16'hF7A2, 16'h10EF};

    // Scoreboard model for instance A: sums pushed on the LEN-th accept.
    logic [23:0] exp_q [$];
    logic [23:0] m_acc = '0;
    int          m_cnt = 0;

    always @(negedge clock) begin
        if (reset) begin
            m_acc = '0;
            m_cnt = 0;
            exp_q.delete();
        end else if (a_in_valid && a_in_ready) begin
            m_acc = m_acc + {{8{a_in_product[15]}}, a_in_product};
            m_cnt++;
            if (m_cnt == 4) begin
                exp_q.push_back(m_acc);
                m_acc = '0;
                m_cnt = 0;
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) tick;
        reset = 1'b0;
        @(negedge clock);
        n_total++;
        if (a_out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", a_out_valid);
        else n_pass++;
        n_total++;
        if (a_in_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", a_in_ready);
        else n_pass++;
        n_total++;
        if (a_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", a_busy);
        else n_pass++;
        n_total++;
        if (a_out_sum !== 24'h000000) $display("FAIL rst_sum: got %h want 000000", a_out_sum);
        else n_pass++;
        n_total++;
        if (a_out_overflow !== 1'b0) $display("FAIL rst_ovf: got %b want 0", a_out_overflow);
        else n_pass++;
    endtask

    task automatic test_basic;
        tick;
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1;
            a_in_product = seq[i];
            tick;
        end
        a_in_valid = 1'b0;
        @(negedge clock);
        n_total++;
        if (a_out_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", a_out_valid);
        else n_pass++;
        n_total++;
        if (a_out_sum !== 24'h000655) $display("FAIL basic_sum: got %h want 000655", a_out_sum);
        else n_pass++;
        n_total++;
        if (a_out_overflow !== 1'b0) $display("FAIL basic_ovf: got %b want 0", a_out_overflow);
        else n_pass++;
        n_total++;
        if (exp_q.size() == 0) $display("FAIL basic_sb: got %h want <none queued>", a_out_sum);
        else if (a_out_sum !== exp_q[0]) $display("FAIL basic_sb: got %h want %h", a_out_sum, exp_q[0]);
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        tick;
        @(negedge clock);
        n_total++;
        if (a_out_valid !== 1'b0) $display("FAIL basic_drain: got %b want 0", a_out_valid);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        tick;
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1;
            a_in_product = seq[i];
            tick;
        end
        a_in_product = 16'h0222;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_total++;
            if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_sum !== 24'h000655)
                $display("FAIL bp_hold[%0d]: got rdy=%b vld=%b sum=%h want rdy=0 vld=1 sum=000655",
                         i, a_in_ready, a_out_valid, a_out_sum);
            else n_pass++;
            tick;
        end
    endtask

    task automatic test_simultaneous;
        a_out_ready = 1'b1;
        @(negedge clock);
        n_total++;
        if (a_in_ready !== 1'b1) $display("FAIL sim_ready: got %b want 1", a_in_ready);
        else n_pass++;
        n_total++;
        if (exp_q.size() == 0) $display("FAIL sim_sb: got %h want <none queued>", a_out_sum);
        else if (a_out_sum !== exp_q[0]) $display("FAIL sim_sb: got %h want %h", a_out_sum, exp_q[0]);
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        tick;
        a_in_valid = 1'b0;
        @(negedge clock);
        n_total++;
        if (a_out_valid !== 1'b0 || a_busy !== 1'b1)
            $display("FAIL sim_next: got vld=%b busy=%b want vld=0 busy=1", a_out_valid, a_busy);
        else n_pass++;
        tick;
        for (int i = 1; i < 4; i++) begin
            a_in_valid = 1'b1;
            a_in_product = seq[i];
            tick;
        end
        a_in_valid = 1'b0;
        @(negedge clock);
        n_total++;
        if (a_out_valid !== 1'b1 || a_out_sum !== 24'h000655)
            $display("FAIL sim_block: got vld=%b sum=%h want vld=1 sum=000655", a_out_valid, a_out_sum);
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        tick;
    endtask

    task automatic test_overflow;
        tick;
        b_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_in_valid = 1'b1;
            b_in_product = 16'h4000;
            tick;
        end
        b_in_valid = 1'b0;
        @(negedge clock);
        n_total++;
        if (b_out_valid !== 1'b1 || b_out_sum !== B_OVF_SUM || b_out_overflow !== 1'b1)
            $display("FAIL ovf_block: got vld=%b sum=%h ovf=%b want vld=1 sum=%h ovf=1",
                     b_out_valid, b_out_sum, b_out_overflow, B_OVF_SUM);
        else n_pass++;
        tick;
        for (int i = 1; i <= 4; i++) begin
            b_in_valid = 1'b1;
            b_in_product = 16'(i);
            tick;
        end
        b_in_valid = 1'b0;
        @(negedge clock);
        n_total++;
        if (b_out_sum !== 16'h000A || b_out_overflow !== 1'b0)
            $display("FAIL ovf_clear: got sum=%h ovf=%b want sum=000a ovf=0", b_out_sum, b_out_overflow);
        else n_pass++;
        tick;
    endtask

    task automatic test_len1;
        tick;
        c_out_ready = 1'b1;
        c_in_valid = 1'b1;
        c_in_product = 16'h0005;
        tick;
        c_in_product = 16'hFFFD;
        @(negedge clock);
        n_total++;
        if (c_out_valid !== 1'b1 || c_out_sum !== 24'h000005 || c_in_ready !== 1'b1)
            $display("FAIL len1_first: got vld=%b sum=%h rdy=%b want vld=1 sum=000005 rdy=1",
                     c_out_valid, c_out_sum, c_in_ready);
        else n_pass++;
        tick;
        c_in_valid = 1'b0;
        @(negedge clock);
        n_total++;
        if (c_out_valid !== 1'b1 || c_out_sum !== 24'hFFFFFD)
            $display("FAIL len1_reload: got vld=%b sum=%h want vld=1 sum=fffffd", c_out_valid, c_out_sum);
        else n_pass++;
        tick;
        @(negedge clock);
        n_total++;
        if (c_out_valid !== 1'b0 || c_busy !== 1'b0)
            $display("FAIL len1_idle: got vld=%b busy=%b want vld=0 busy=0", c_out_valid, c_busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid_block;
        tick;
        a_out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a_in_valid = 1'b1;
            a_in_product = 16'h1000;
            tick;
        end
        a_in_valid = 1'b0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        @(negedge clock);
        n_total++;
        if (a_out_valid !== 1'b0 || a_busy !== 1'b0)
            $display("FAIL mid_rst: got vld=%b busy=%b want vld=0 busy=0", a_out_valid, a_busy);
        else n_pass++;
        tick;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1;
            a_in_product = seq[i];
            tick;
        end
        a_in_valid = 1'b0;
        @(negedge clock);
        n_total++;
        if (a_out_valid !== 1'b1 || a_out_sum !== 24'h000655)
            $display("FAIL mid_block: got vld=%b sum=%h want vld=1 sum=000655", a_out_valid, a_out_sum);
        else n_pass++;
        n_total++;
        if (exp_q.size() != 1) $display("FAIL mid_sb: got %0d queued want 1", exp_q.size());
        else if (a_out_sum !== exp_q[0]) $display("FAIL mid_sb: got %h want %h", a_out_sum, exp_q[0]);
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        tick;
    endtask

    task automatic test_back_to_back;
        int   idx;
        int   cyc;
        logic acc_now;
        idx = 0;
        cyc = 0;
        a_in_valid = 1'b0;
        tick;
        while ((idx < 40 || exp_q.size() != 0) && cyc < 3000) begin
            if (!a_in_valid && idx < 40 && $urandom_range(0, 3) != 0) begin
                a_in_valid = 1'b1;
                a_in_product = 16'($urandom);
            end
            a_out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clock);
            acc_now = a_in_valid && a_in_ready;
            if (a_out_valid && a_out_ready) begin
                n_total++;
                if (exp_q.size() == 0)
                    $display("FAIL b2b_sum: got %h want <none queued>", a_out_sum);
                else if (a_out_sum !== exp_q[0] || a_out_overflow !== 1'b0)
                    $display("FAIL b2b_sum: got %h ovf=%b want %h ovf=0",
                             a_out_sum, a_out_overflow, exp_q[0]);
                else n_pass++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            tick;
            if (acc_now) begin
                idx++;
                a_in_valid = 1'b0;
            end
            cyc++;
        end
        n_total++;
        if (idx != 40 || exp_q.size() != 0)
            $display("FAIL b2b_done: got %0d accepted %0d pending want 40 accepted 0 pending",
                     idx, exp_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_simultaneous;
        test_overflow;
        test_len1;
        test_reset_mid_block;
        test_back_to_back;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
